// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: datapath width, funct3
// size codes, FSM encoding and the byte-enable / fault helpers.
package load_store_unit_pkg;

  localparam int LSU_DATA_BITS = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  // Size comes from funct3[1:0]; the sign bit does not change lane selection.
  function automatic logic [3:0] lsu_be(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   lsu_be = 4'b0001 << a;
      2'b01:   lsu_be = a[1] ? 4'b1100 : 4'b0011;
      default: lsu_be = 4'b1111;
    endcase
  endfunction

  function automatic logic lsu_fault(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_B, F3_BU: lsu_fault = 1'b0;
      F3_H, F3_HU: lsu_fault = a[0];
      F3_W:        lsu_fault = |a;
      default:     lsu_fault = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-addressed data-memory bus between the load/store unit and memory.
interface load_store_unit_if #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32
);
  logic                 dmem_req;
  logic                 dmem_we;
  logic [3:0]           dmem_be;
  logic [ADDR_BITS-3:0] dmem_addr;
  logic [DATA_BITS-1:0] dmem_wdata;
  logic [DATA_BITS-1:0] dmem_rdata;
  logic                 dmem_stall;

  modport master (
    output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_stall
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_stall
  );
endinterface

// File: rtl/load_store_unit_load_align.sv
// Combinational load lane extraction with sign/zero extension.
module lsu_load_align
  import load_store_unit_pkg::*;
#(
  parameter int DATA_BITS = LSU_DATA_BITS
) (
  input  logic [DATA_BITS-1:0] rdata,
  input  logic [1:0]           addr_lo,
  input  logic [2:0]           funct3,
  output logic [DATA_BITS-1:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[{addr_lo, 3'b000} +: 8];
    h = rdata[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    data = {{(DATA_BITS-8){b[7]}}, b};
      F3_BU:   data = {{(DATA_BITS-8){1'b0}}, b};
      F3_H:    data = {{(DATA_BITS-16){h[15]}}, h};
      F3_HU:   data = {{(DATA_BITS-16){1'b0}}, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: IDLE -> (ACCESS) -> RESP per op, one op in flight.
// Outputs are gated by state so IDLE (and reset) drives them all low.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DATA_BITS = LSU_DATA_BITS,
  parameter int ADDR_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic [DATA_BITS-1:0] alu_result,
  input  logic [DATA_BITS-1:0] store_data,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [2:0]           funct3,
  input  logic [4:0]           rd,
  input  logic                 reg_write,
  load_store_unit_if.master    dmem,
  output logic                 wb_valid,
  output logic [DATA_BITS-1:0] wb_data,
  output logic [4:0]           wb_rd,
  output logic                 wb_reg_write,
  output logic                 misalign
);

  lsu_state_e           state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic [DATA_BITS-1:0] res_q, res_d;
  logic [3:0]           be_q, be_d;
  logic [2:0]           f3_q, f3_d;
  logic [4:0]           rd_q, rd_d;
  logic                 rw_q, rw_d;
  logic                 st_q, st_d;
  logic                 ld_q, ld_d;
  logic                 flt_q, flt_d;
  logic [DATA_BITS-1:0] ld_data;
  logic                 mem_op, in_acc, in_resp;

  lsu_load_align #(.DATA_BITS(DATA_BITS)) u_align (
    .rdata   (dmem.dmem_rdata),
    .addr_lo (addr_q[1:0]),
    .funct3  (f3_q),
    .data    (ld_data)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    res_d   = res_q;
    be_d    = be_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    st_d    = st_q;
    ld_d    = ld_q;
    flt_d   = flt_q;
    mem_op  = mem_read | mem_write;
    case (state_q)
      IDLE: if (ex_valid) begin
        addr_d = alu_result[ADDR_BITS-1:0];
        res_d  = alu_result;
        f3_d   = funct3;
        rd_d   = rd;
        rw_d   = reg_write;
        st_d   = mem_write;
        ld_d   = mem_read & ~mem_write;
        flt_d  = mem_op & lsu_fault(funct3, alu_result[1:0]);
        be_d   = lsu_be(funct3[1:0], alu_result[1:0]);
        case (funct3[1:0])
          2'b00:   wdata_d = {(DATA_BITS/8){store_data[7:0]}};
          2'b01:   wdata_d = {(DATA_BITS/16){store_data[15:0]}};
          default: wdata_d = store_data;
        endcase
        state_d = (mem_op && !flt_d) ? ACCESS : RESP;
      end
      ACCESS: if (!dmem.dmem_stall) begin
        state_d = RESP;
        if (ld_q) res_d = ld_data;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      res_q   <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      st_q    <= 1'b0;
      ld_q    <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      res_q   <= res_d;
      be_q    <= be_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      st_q    <= st_d;
      ld_q    <= ld_d;
      flt_q   <= flt_d;
    end
  end

  assign in_acc  = (state_q == ACCESS);
  assign in_resp = (state_q == RESP);

  assign ex_ready        = (state_q == IDLE);
  assign dmem.dmem_req   = in_acc;
  assign dmem.dmem_we    = in_acc & st_q;
  assign dmem.dmem_be    = in_acc ? be_q : 4'b0000;
  assign dmem.dmem_addr  = in_acc ? addr_q[ADDR_BITS-1:2] : '0;
  assign dmem.dmem_wdata = in_acc ? wdata_q : '0;

  assign wb_valid     = in_resp;
  assign wb_data      = in_resp ? res_q : '0;
  assign wb_rd        = in_resp ? rd_q : 5'd0;
  assign wb_reg_write = in_resp & rw_q & ~st_q & ~flt_q & (|rd_q);
  assign misalign     = in_resp & flt_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit with a stalling memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready;
  logic [31:0] alu_result, store_data;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        reg_write;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write, misalign;

  int total = 0;
  int bad   = 0;

  load_store_unit_if #(.ADDR_BITS(32), .DATA_BITS(32)) bus ();

  load_store_unit #(.DATA_BITS(32), .ADDR_BITS(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .alu_result   (alu_result),
    .store_data   (store_data),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .funct3       (funct3),
    .rd           (rd),
    .reg_write    (reg_write),
    .dmem         (bus.master),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data),
    .wb_rd        (wb_rd),
    .wb_reg_write (wb_reg_write),
    .misalign     (misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] sd;
    logic        mr;
    logic        mw;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] rdat;
    int          stall;
    logic        mem;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        we;
    logic [31:0] wbd;
    logic        wrw;
    logic        mis;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          cyc, nreq;
    logic        got, unstable;
    logic [3:0]  be0;
    logic [29:0] a0;
    logic [31:0] wd0, wbd;
    logic        we0, wrw, mis;
    logic [4:0]  wrd;
    cyc = 0; nreq = 0; got = 0; unstable = 0;
    be0 = '0; a0 = '0; wd0 = '0; we0 = 0; wbd = '0; wrw = 0; mis = 0; wrd = '0;
    @(negedge clk);
    alu_result = v.alu; store_data = v.sd; mem_read = v.mr; mem_write = v.mw;
    funct3 = v.f3; rd = v.rd; reg_write = v.rw;
    bus.dmem_rdata = v.rdat;
    bus.dmem_stall = (v.stall > 0);
    ex_valid = 1'b1;
    chk($sformatf("v%0d_ready", idx), {31'd0, ex_ready}, 32'd1);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    while (!got && cyc < 20) begin
      cyc++;
      if (bus.dmem_req) begin
        nreq++;
        if (nreq == 1) begin
          be0 = bus.dmem_be; a0 = bus.dmem_addr; wd0 = bus.dmem_wdata; we0 = bus.dmem_we;
        end else if (be0 !== bus.dmem_be || a0 !== bus.dmem_addr ||
                     wd0 !== bus.dmem_wdata || we0 !== bus.dmem_we) begin
          unstable = 1'b1;
        end
        bus.dmem_stall = (nreq < v.stall + 1) ? 1'b1 : 1'b0;
      end
      if (wb_valid) begin
        got = 1'b1; wbd = wb_data; wrw = wb_reg_write; mis = misalign; wrd = wb_rd;
      end else begin
        @(posedge clk); #1;
      end
    end
    bus.dmem_stall = 1'b0;
    chk($sformatf("v%0d_wb_seen", idx), {31'd0, got}, 32'd1);
    chk($sformatf("v%0d_latency", idx), cyc, v.mem ? v.stall + 2 : 1);
    chk($sformatf("v%0d_nreq", idx), nreq, v.mem ? v.stall + 1 : 0);
    if (v.mem) begin
      chk($sformatf("v%0d_be", idx), {28'd0, be0}, {28'd0, v.be});
      chk($sformatf("v%0d_addr", idx), {2'b00, a0}, v.alu >> 2);
      chk($sformatf("v%0d_wdata", idx), wd0, v.wd);
      chk($sformatf("v%0d_we", idx), {31'd0, we0}, {31'd0, v.we});
      chk($sformatf("v%0d_stable", idx), {31'd0, unstable}, 32'd0);
    end
    chk($sformatf("v%0d_wb_data", idx), wbd, v.wbd);
    chk($sformatf("v%0d_wb_rd", idx), {27'd0, wrd}, {27'd0, v.rd});
    chk($sformatf("v%0d_wb_rw", idx), {31'd0, wrw}, {31'd0, v.wrw});
    chk($sformatf("v%0d_misalign", idx), {31'd0, mis}, {31'd0, v.mis});
    @(posedge clk); #1;
    chk($sformatf("v%0d_wb_drop", idx), {31'd0, wb_valid}, 32'd0);
    chk($sformatf("v%0d_idle_ready", idx), {31'd0, ex_ready}, 32'd1);
  endtask

  initial begin
    int seen;
    //          alu          sd            mr mw f3      rd  rw rdat          st mem be       wd            we wbd           wrw mis
    vecs[0]  = '{32'h10,     32'h0,        0, 0, 3'b000, 5,  1, 32'h0,        0, 0, 4'b0000, 32'h0,        0, 32'h10,       1, 0};
    vecs[1]  = '{32'h1003,   32'h0,        1, 0, 3'b000, 6,  1, 32'h80FF0000, 0, 1, 4'b1000, 32'h0,        0, 32'hFFFFFF80, 1, 0};
    vecs[2]  = '{32'h2002,   32'h0,        1, 0, 3'b101, 7,  1, 32'hBEEF1234, 3, 1, 4'b1100, 32'h0,        0, 32'h0000BEEF, 1, 0};
    vecs[3]  = '{32'h3001,   32'hAB,       0, 1, 3'b000, 8,  1, 32'h0,        0, 1, 4'b0010, 32'hABABABAB, 1, 32'h3001,     0, 0};
    vecs[4]  = '{32'h4002,   32'h0,        1, 0, 3'b010, 9,  1, 32'h0,        0, 0, 4'b0000, 32'h0,        0, 32'h4002,     0, 1};
    vecs[5]  = '{32'h5000,   32'h0,        1, 0, 3'b010, 10, 1, 32'h12345678, 0, 1, 4'b1111, 32'h0,        0, 32'h12345678, 1, 0};
    vecs[6]  = '{32'h6000,   32'h0,        1, 0, 3'b001, 11, 1, 32'h12348001, 0, 1, 4'b0011, 32'h0,        0, 32'hFFFF8001, 1, 0};
    vecs[7]  = '{32'h7001,   32'h0,        1, 0, 3'b100, 12, 1, 32'h0000C300, 0, 1, 4'b0010, 32'h0,        0, 32'h000000C3, 1, 0};
    vecs[8]  = '{32'h8002,   32'h1234CAFE, 0, 1, 3'b001, 13, 0, 32'h0,        0, 1, 4'b1100, 32'hCAFECAFE, 1, 32'h8002,     0, 0};
    vecs[9]  = '{32'h9000,   32'hDEADBEEF, 0, 1, 3'b010, 14, 0, 32'h0,        1, 1, 4'b1111, 32'hDEADBEEF, 1, 32'h9000,     0, 0};
    vecs[10] = '{32'hA004,   32'h11223344, 1, 1, 3'b010, 15, 1, 32'hFFFFFFFF, 0, 1, 4'b1111, 32'h11223344, 1, 32'hA004,     0, 0};
    vecs[11] = '{32'h55,     32'h0,        0, 0, 3'b000, 0,  1, 32'h0,        0, 0, 4'b0000, 32'h0,        0, 32'h55,       0, 0};
    vecs[12] = '{32'hB000,   32'h0,        1, 0, 3'b011, 16, 1, 32'h0,        0, 0, 4'b0000, 32'h0,        0, 32'hB000,     0, 1};
    vecs[13] = '{32'hC001,   32'h0,        1, 0, 3'b001, 17, 1, 32'h0,        0, 0, 4'b0000, 32'h0,        0, 32'hC001,     0, 1};
    vecs[14] = '{32'h77,     32'h0,        0, 0, 3'b011, 3,  1, 32'h0,        0, 0, 4'b0000, 32'h0,        0, 32'h77,       1, 0};
    vecs[15] = '{32'hD000,   32'h0,        1, 0, 3'b000, 18, 1, 32'h0000007F, 0, 1, 4'b0001, 32'h0,        0, 32'h0000007F, 1, 0};

    rst = 1'b1; ex_valid = 0; alu_result = '0; store_data = '0; mem_read = 0;
    mem_write = 0; funct3 = '0; rd = '0; reg_write = 0;
    bus.dmem_rdata = '0; bus.dmem_stall = 1'b0;
    #12;
    chk("rst_ready", {31'd0, ex_ready}, 32'd1);
    chk("rst_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Reset in the middle of a stalled access: request dropped, nothing written back.
    @(negedge clk);
    alu_result = 32'hE000; mem_read = 1; mem_write = 0; funct3 = 3'b010; rd = 5'd4; reg_write = 1;
    bus.dmem_stall = 1'b1; ex_valid = 1'b1;
    @(posedge clk); #1; ex_valid = 1'b0;
    chk("rstacc_req_c1", {31'd0, bus.dmem_req}, 32'd1);
    @(posedge clk); #1;
    chk("rstacc_req_c2", {31'd0, bus.dmem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstacc_req_drop", {31'd0, bus.dmem_req}, 32'd0);
    chk("rstacc_ready", {31'd0, ex_ready}, 32'd1);
    chk("rstacc_be", {28'd0, bus.dmem_be}, 32'd0);
    @(posedge clk); #1; rst = 1'b0; bus.dmem_stall = 1'b0;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (wb_valid || bus.dmem_req) seen++;
    end
    chk("rstacc_no_wb", seen, 0);
    run_vec(vecs[0], 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_BITS, default 32, datapath width (must match the ALU width).
REQ-002 SHALL have parameter ADDR_BITS, default 32, byte-address width taken from the ALU result.
REQ-003 SHALL have one clock and asynchronous active-high reset; ports are named clk and rst.
REQ-004 Port clk, input, 1, rising-edge clock.
REQ-005 Port rst, input, 1, asynchronous active-high reset.
REQ-006 Port ex_valid, input, 1, EX stage presents an op.
REQ-007 Port ex_ready, output, 1, unit accepts an op this cycle.
REQ-008 Port alu_result, input, DATA_BITS, effective address or arithmetic result.
REQ-009 Port store_data, input, DATA_BITS, rs2 value for stores.
REQ-010 Ports mem_read and mem_write, input, 1 each, op type.
REQ-011 Port funct3, input, 3, size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-012 Ports rd (input, 5) and reg_write (input, 1), destination register and write enable.
REQ-013 Ports dmem_req, dmem_we, dmem_be, dmem_addr and dmem_wdata, output, widths 1/1/4/ADDR_BITS-2/DATA_BITS, word-addressed memory request.
REQ-014 Ports dmem_rdata (input, DATA_BITS) and dmem_stall (input, 1), read word and memory busy.
REQ-015 Ports wb_valid, wb_data, wb_rd and wb_reg_write, output, widths 1/DATA_BITS/5/1, writeback result.
REQ-016 Port misalign, output, 1, fault pulse coincident with wb_valid.

Function
REQ-017 FSM SHALL have the states IDLE, ACCESS and RESP; ex_ready SHALL be 1 only in IDLE.
REQ-018 An op is accepted when ex_valid and ex_ready are both high; all inputs are latched on that edge.
REQ-019 For a non-memory op, the unit SHALL go IDLE -> RESP, then assert wb_valid for 1 cycle with wb_data = alu_result (latency 1).
REQ-020 For an aligned memory op, the unit SHALL go IDLE -> ACCESS.
REQ-021 In ACCESS, dmem_req SHALL be held high with stable address, byte enables and write data.
REQ-022 The unit SHALL leave ACCESS for RESP on the first edge with dmem_stall low; minimum latency is 2.
REQ-023 On that ACCESS exit edge, load data SHALL be sampled from dmem_rdata.
REQ-024 RESP SHALL last exactly 1 cycle, then return to IDLE.
REQ-025 Byte enables SHALL be: SB 1<<addr[1:0]; SH 0011 if addr[1]=0, else 1100; SW 1111.
REQ-026 Store data SHALL be replicated across byte lanes: byte x4, halfword x2.
REQ-027 Loads SHALL extract the addressed lane: B/H sign-extend, BU/HU zero-extend, W passes through.
REQ-028 H/HU with addr[0]=1, W with addr[1:0]!=0, or an undefined funct3 (011, 110, 111) SHALL count as a fault.
REQ-029 On a fault, the unit SHALL issue no dmem_req and go IDLE -> RESP with misalign=1, wb_reg_write=0 and wb_data = alu_result.
REQ-030 If mem_read and mem_write are both set, store SHALL take priority.
REQ-031 Stores SHALL produce wb_valid with wb_reg_write=0.
REQ-032 A write to rd=0 SHALL force wb_reg_write=0.
REQ-033 dmem_we SHALL equal the latched mem_write while dmem_req is high, and 0 otherwise.

Reset
REQ-034 rst SHALL immediately force IDLE and drive all outputs to 0, except ex_ready, which SHALL go to 1.
REQ-035 A reset during ACCESS SHALL abandon the request with no retry and no writeback.

Structure
REQ-036 A shared package SHALL hold DATA_BITS, the funct3 size codes and the FSM state encoding.
REQ-037 Load extraction and extension SHALL live in a sub-module lsu_load_align, which is purely combinational.

Verification
REQ-038 ADD op, alu_result=0x00000010, rd=5 -> wb_valid one cycle after accept, wb_data=0x10, wb_rd=5.
REQ-039 LB at 0x1003, dmem_rdata=0x80FF_0000, no stall -> dmem_be=1000; 2 cycles later wb_data=0xFFFFFF80.
REQ-040 LHU at 0x2002, dmem_rdata=0xBEEF_1234, dmem_stall high for 3 cycles -> dmem_req high for 4 cycles; wb_data=0x0000BEEF.
REQ-041 SB at 0x3001, store_data=0x000000AB -> dmem_wdata=0xABABABAB, dmem_be=0010, dmem_we=1, wb_reg_write=0.
REQ-042 LW at 0x4002 -> no dmem_req; misalign=1 and wb_reg_write=0, both with wb_valid.
REQ-043 rst asserted during ACCESS with stall high -> dmem_req drops immediately, no wb_valid, ex_ready=1.
